// File: rtl/chaos_pkg.sv
// Shared types and constants for the logistic-map keystream generator.
package chaos_pkg;

    localparam int X_W_DEF      = 32;
    localparam int NUM_KEYS_DEF = 65536;
    localparam int KEY_CNT_W    = 17;
    // x is Q0.X_W; r carries two integer bits, so its fraction is X_W - R_INT_BITS
    localparam int R_INT_BITS   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BURN,
        ST_RUN_S1,
        ST_RUN_S2,
        ST_HOLD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/chaotic_keystream_gen_if.sv
// Control and key-output handshake bundle between the keystream generator and its user.
interface chaotic_keystream_gen_if #(
    parameter int X_W = 32
);
    logic           start;
    logic [X_W-1:0] seed;
    logic [X_W-1:0] r_coef;
    logic           key_valid;
    logic           key_ready;
    logic [7:0]     key_byte;
    logic           busy;
    logic           done;
    logic           seed_err;

    modport master (
        output start, seed, r_coef, key_ready,
        input  key_valid, key_byte, busy, done, seed_err
    );

    modport slave (
        input  start, seed, r_coef, key_ready,
        output key_valid, key_byte, busy, done, seed_err
    );
endinterface

// File: rtl/logistic_iter.sv
// Two-stage logistic-map datapath: S1 registers t = x*(1-x), S2 registers x' = r*t with saturation.
module logistic_iter
    import chaos_pkg::*;
#(
    parameter int X_W = X_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_i,
    input  logic [X_W-1:0] x_i,
    input  logic [X_W-1:0] r_i,
    input  logic           s1_en_i,
    input  logic           s2_en_i,
    output logic [X_W-1:0] x_nxt_o
);

    logic [X_W-1:0]   x_q;
    logic [X_W-1:0]   t_q;
    logic [X_W-1:0]   t_d;
    logic [X_W:0]     one_m_x;
    logic [2*X_W:0]   s1_prod;
    logic [2*X_W-1:0] s2_prod;
    logic             unused_bits;

    function automatic logic [X_W-1:0] sat_x(input logic [X_W+1:0] v);
        return (|v[X_W+1:X_W]) ? {X_W{1'b1}} : v[X_W-1:0];
    endfunction

    // 1 - x needs one extra bit because x == 0 gives exactly 2^X_W
    assign one_m_x = {1'b1, {X_W{1'b0}}} - {1'b0, x_q};
    assign s1_prod = (2*X_W+1)'(one_m_x) * (2*X_W+1)'(x_q);
    assign t_d     = s1_prod[2*X_W-1 -: X_W];

    assign s2_prod = (2*X_W)'(r_i) * (2*X_W)'(t_q);
    assign x_nxt_o = sat_x(s2_prod[2*X_W-1 : X_W-R_INT_BITS]);

    assign unused_bits = ^{s1_prod[2*X_W], s1_prod[X_W-1:0], s2_prod[X_W-R_INT_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= '0;
            x_q <= '0;
        end else begin
            if (s1_en_i) begin
                t_q <= t_d;
            end
            if (ld_i) begin
                x_q <= x_i;
            end else if (s2_en_i) begin
                x_q <= x_nxt_o;
            end
        end
    end

endmodule

// File: rtl/chaotic_keystream_gen.sv
// Logistic-map keystream generator: seed, burn-in, then one key byte per iteration with a valid/ready handshake.
// Optional build macro KEYGEN_WHITEN_EN folds the low state byte into each key byte.
module chaotic_keystream_gen
    import chaos_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int DISCARD  = 100,
    parameter int NUM_KEYS = NUM_KEYS_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    chaotic_keystream_gen_if.slave bus
);

    state_e               state_q;
    logic                 phase_q;
    logic [31:0]          burn_cnt_q;
    logic [KEY_CNT_W-1:0] key_cnt_q;
    logic [KEY_CNT_W-1:0] key_cnt_d;
    logic [X_W-1:0]       r_q;
    logic                 key_valid_q;
    logic [7:0]           key_byte_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 seed_err_q;

    logic                 start_ok;
    logic                 s1_en;
    logic                 s2_en;
    logic [X_W-1:0]       x_nxt;

    function automatic logic [7:0] key_of(input logic [X_W-1:0] x);
`ifdef KEYGEN_WHITEN_EN
        return x[X_W-1 -: 8] ^ x[7:0];
`else
        return x[X_W-1 -: 8];
`endif
    endfunction

    assign start_ok  = bus.start && (bus.seed != '0) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Burn-in alternates S1/S2 on phase_q; the run states sequence them explicitly
    assign s1_en     = (state_q == ST_RUN_S1) || ((state_q == ST_BURN) && !phase_q);
    assign s2_en     = (state_q == ST_RUN_S2) || ((state_q == ST_BURN) &&  phase_q);
    assign key_cnt_d = key_cnt_q + 1'b1;

    logistic_iter #(.X_W(X_W)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (start_ok),
        .x_i     (bus.seed),
        .r_i     (r_q),
        .s1_en_i (s1_en),
        .s2_en_i (s2_en),
        .x_nxt_o (x_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            burn_cnt_q  <= '0;
            key_cnt_q   <= '0;
            r_q         <= '0;
            key_valid_q <= 1'b0;
            key_byte_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seed_err_q  <= 1'b0;
        end else begin
            seed_err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start && (bus.seed == '0)) begin
                        seed_err_q <= 1'b1;
                    end else if (start_ok) begin
                        r_q        <= bus.r_coef;
                        phase_q    <= 1'b0;
                        burn_cnt_q <= '0;
                        key_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= (DISCARD == 0) ? ST_RUN_S1 : ST_BURN;
                    end
                end
                ST_BURN: begin
                    phase_q <= !phase_q;
                    if (phase_q) begin
                        burn_cnt_q <= burn_cnt_q + 32'd1;
                        if (burn_cnt_q == 32'(DISCARD - 1)) begin
                            state_q <= ST_RUN_S1;
                        end
                    end
                end
                ST_RUN_S1: begin
                    state_q <= ST_RUN_S2;
                end
                ST_RUN_S2: begin
                    key_valid_q <= 1'b1;
                    key_byte_q  <= key_of(x_nxt);
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.key_ready) begin
                        key_valid_q <= 1'b0;
                        key_cnt_q   <= key_cnt_d;
                        if (key_cnt_d == KEY_CNT_W'(NUM_KEYS)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN_S1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_byte  = key_byte_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.seed_err  = seed_err_q;

endmodule

// File: tb/tb_chaotic_keystream_gen.sv
// Bench for chaotic_keystream_gen: two instances (no burn-in / 4 keys, 100 burn-in / 1000 keys) against a plain-arithmetic logistic-map model.
module tb_chaotic_keystream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   n_chk = 0;
    int   n_err = 0;

    chaotic_keystream_gen_if #(.X_W(32)) ifa ();
    chaotic_keystream_gen_if #(.X_W(32)) ifb ();

    chaotic_keystream_gen #(.X_W(32), .DISCARD(0), .NUM_KEYS(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    chaotic_keystream_gen #(.X_W(32), .DISCARD(100), .NUM_KEYS(1000)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    // x' = r*x*(1-x) with x in Q0.32 and r in Q2.30, computed in 64-bit integers
    function automatic logic [31:0] ref_next(input logic [31:0] x, input logic [31:0] r);
        logic [63:0] xv, rv, t, p;
        xv = {32'd0, x};
        rv = {32'd0, r};
        t  = (xv * (64'h1_0000_0000 - xv)) >> 32;
        p  = (rv * t) >> 30;
        if (p > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return p[31:0];
    endfunction

    function automatic logic [7:0] ref_key(input logic [31:0] x);
`ifdef KEYGEN_WHITEN_EN
        return x[31:24] ^ x[7:0];
`else
        return x[31:24];
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random backpressure and stray start pulses; every handshake is scored against the model.
    task automatic drain(input int which, input logic [31:0] x0, input logic [31:0] r,
                         input int budget, output int hs);
        logic [31:0] x;
        logic        kv, kr, dn, st;
        logic [7:0]  kb;
        int          cyc;
        x   = x0;
        hs  = 0;
        cyc = 0;
        while (cyc < budget) begin
            if (which == 0) begin
                kv = ifa.key_valid; kb = ifa.key_byte; dn = ifa.done;
            end else begin
                kv = ifb.key_valid; kb = ifb.key_byte; dn = ifb.done;
            end
            if (dn) break;
            kr = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0) || (kv && kr);
            if (which == 0) begin
                ifa.key_ready = kr; ifa.start = st;
            end else begin
                ifb.key_ready = kr; ifb.start = st;
            end
            if (kv && kr) begin
                x = ref_next(x, r);
                chk("key", {56'd0, kb}, {56'd0, ref_key(x)});
                hs++;
            end
            tick();
            cyc++;
        end
        if (which == 0) begin
            ifa.key_ready = 1'b0; ifa.start = 1'b0;
        end else begin
            ifb.key_ready = 1'b0; ifb.start = 1'b0;
        end
    endtask

    initial begin
        int          n;
        int          hs;
        logic [31:0] xm;
        logic [31:0] sd;
        logic [31:0] rc;

        rst_a = 1'b1; rst_b = 1'b1;
        ifa.start = 1'b0; ifa.seed = '0; ifa.r_coef = '0; ifa.key_ready = 1'b0;
        ifb.start = 1'b0; ifb.seed = '0; ifb.r_coef = '0; ifb.key_ready = 1'b0;
        repeat (2) tick();
        rst_a = 1'b0; rst_b = 1'b0;

        chk("rst_kv",   ifa.key_valid, 0);
        chk("rst_kb",   ifa.key_byte,  0);
        chk("rst_busy", ifa.busy,      0);
        chk("rst_done", ifa.done,      0);
        chk("rst_serr", ifa.seed_err,  0);
        chk("rst_b_kv", ifb.key_valid, 0);

        // Zero seed: error pulse, no frame starts
        ifa.seed = 32'h0; ifa.r_coef = 32'hF000_0000; ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("serr_pulse", ifa.seed_err, 1);
        chk("serr_busy",  ifa.busy,     0);
        tick();
        chk("serr_clear", ifa.seed_err,  0);
        chk("serr_idle",  ifa.busy,      0);
        chk("serr_kv",    ifa.key_valid, 0);

        // First key latency with no burn-in, then a 10-cycle stall
        ifa.seed = 32'h8000_0000; ifa.start = 1'b1; ifa.key_ready = 1'b0;
        n = 0;
        do begin
            tick();
            ifa.start = 1'b0;
            n++;
        end while (!ifa.key_valid && n < 20);
        chk("lat_a", n, 3);
        chk("key0",  ifa.key_byte, 8'hF0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_kv", ifa.key_valid, 1);
            chk("stall_kb", ifa.key_byte,  8'hF0);
        end
        drain(0, 32'h8000_0000, 32'hF000_0000, 200, hs);
        chk("a_hs",   hs, 4);
        chk("a_done", ifa.done, 1);
        chk("a_busy", ifa.busy, 0);
        chk("a_kv",   ifa.key_valid, 0);
        repeat (2) tick();
        chk("a_done_hold", ifa.done, 1);
        chk("a_busy_hold", ifa.busy, 0);

        // Random seeds and coefficients, restarting from DONE
        for (int k = 0; k < 3; k++) begin
            sd = $urandom | 32'h1;
            rc = 32'hE000_0000 | ($urandom & 32'h1FFF_FFFF);
            ifa.seed = sd; ifa.r_coef = rc; ifa.start = 1'b1;
            tick();
            ifa.start = 1'b0;
            chk("re_done", ifa.done, 0);
            chk("re_busy", ifa.busy, 1);
            drain(0, sd, rc, 200, hs);
            chk("re_hs",   hs, 4);
            chk("re_fin",  ifa.done, 1);
        end

        // Reset in the middle of burn-in
        ifb.seed = 32'h1234_5678; ifb.r_coef = 32'hFD70_A3D7; ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        chk("b_busy", ifb.busy, 1);
        repeat (49) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("mid_kv",   ifb.key_valid, 0);
        chk("mid_kb",   ifb.key_byte,  0);
        chk("mid_busy", ifb.busy,      0);
        chk("mid_done", ifb.done,      0);
        chk("mid_serr", ifb.seed_err,  0);

        // Clean restart: 100 burn-in iterations, then 1000 scored keys
        ifb.start = 1'b1;
        n = 0;
        do begin
            tick();
            ifb.start = 1'b0;
            n++;
        end while (!ifb.key_valid && n < 400);
        chk("lat_b", n, 203);
        xm = 32'h1234_5678;
        for (int i = 0; i < 100; i++) xm = ref_next(xm, 32'hFD70_A3D7);
        drain(1, xm, 32'hFD70_A3D7, 9000, hs);
        chk("b_hs",   hs, 1000);
        chk("b_done", ifb.done, 1);
        chk("b_busy_end", ifb.busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chaotic_keystream_gen.md
CHAOTIC_KEYSTREAM_GEN -- requirements
Module: chaotic_keystream_gen

Interface
REQ-001 SHALL have parameter X_W, default 32, state width; x is unsigned Q0.X_W in [0,1).
REQ-002 SHALL have parameter DISCARD, default 100, burn-in iterations run after seeding and never output.
REQ-003 SHALL have parameter NUM_KEYS, default 65536, key bytes per frame (one per pixel of a 256x256 image).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; loads seed and r_coef when the FSM is in IDLE or DONE.
REQ-007 seed  in  X_W  initial x (Q0.X_W).
REQ-008 r_coef  in  X_W  logistic coefficient r, unsigned Q2.(X_W-2).
REQ-009 key_valid  out  1  key_byte is valid.
REQ-010 key_ready  in  1  downstream substitution stage accepts key_byte.
REQ-011 key_byte  out  8  per-pixel key byte.
REQ-012 busy  out  1  high in BURN or RUN.
REQ-013 done  out  1  high in DONE, until the next start or rst.
REQ-014 seed_err  out  1  one-cycle pulse when start is seen with seed == 0.

Function
REQ-015 SHALL iterate x' = r*x*(1-x) using two registered stages:
- S1: t = (x * (2^X_W - x)) >> X_W.
- S2: x' = (r_coef * t) >> (X_W-2), saturated to 2^X_W-1 on overflow.
- One iteration takes exactly 2 cycles.
REQ-016 FSM states SHALL be IDLE, BURN, RUN_S1, RUN_S2, HOLD, DONE.
REQ-017 IDLE/DONE + start + seed != 0 SHALL load x = seed and r = r_coef, clear counters, then go to BURN (or to RUN_S1 if DISCARD == 0).
REQ-018 IDLE/DONE + start + seed == 0 SHALL pulse seed_err the next cycle and leave the state unchanged.
REQ-019 BURN SHALL run DISCARD full iterations (2*DISCARD cycles), then go to RUN_S1.
REQ-020 RUN_S2 SHALL register the new x, go to HOLD, and assert key_valid from the next cycle with key_byte = x[X_W-1 -: 8].
REQ-021 In HOLD, key_valid and key_byte SHALL stay stable until key_ready.
REQ-022 The handshake (key_valid && key_ready) SHALL increment the key counter; if the count reaches NUM_KEYS the FSM goes to DONE, otherwise to RUN_S1.
REQ-023 Steady-state throughput with key_ready tied high SHALL be one key per 3 cycles: S1, S2, HOLD.
REQ-024 start asserted while busy SHALL be ignored; start in the same cycle as the last handshake SHALL be ignored.
REQ-025 The key counter SHALL be 17 bits wide and SHALL not wrap within a frame.

Reset
REQ-026 rst SHALL force IDLE and clear x, r, t, all counters, key_valid, key_byte, busy, done and seed_err to 0 on the next edge.
REQ-027 rst SHALL take priority over start and the handshake, including mid-BURN and mid-HOLD; there is no partial-frame resume.

Configuration
REQ-028 KEYGEN_WHITEN_EN defined: key_byte SHALL be x[X_W-1 -: 8] XOR x[7:0].
REQ-029 KEYGEN_WHITEN_EN undefined: key_byte SHALL be x[X_W-1 -: 8] only.

Structure
REQ-030 A shared package chaos_pkg SHALL hold the FSM state enum, X_W, the default NUM_KEYS, and the fixed-point fraction constants.
REQ-031 The two-stage datapath SHALL be a sub-module logistic_iter (inputs x, r, stage enable; output x').

Verification
REQ-032 DISCARD=0, seed=0x8000_0000, r_coef=0xF000_0000, start -> first key_valid 3 cycles after start, key_byte=0xF0 (either config).
REQ-033 The same seed with key_ready low for 10 cycles -> key_byte stable at 0xF0 and key_valid held; the counter advances only on the ready cycle.
REQ-034 seed=0, start -> seed_err high for exactly 1 cycle; busy stays 0; state stays IDLE.
REQ-035 NUM_KEYS=4, key_ready=1 -> exactly 4 handshakes, then done=1, busy=0; start during RUN is ignored.
REQ-036 rst pulsed mid-BURN (DISCARD=100, cycle 50) -> all outputs 0 the next cycle; a new start gives keys identical to a clean run.
REQ-037 Bit-exact scoreboard against the reference model for 1000 keys, seed=0x1234_5678, r_coef=0xFD70_A3D7, run with the macro both defined and undefined.
